// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute stage: ALU op codes, forwarding
// select codes and the iterative multiplier state encoding.
// No ports; imported by execute_stage and mul_iter.
package mips_pkg;

  // ALU operation codes carried on ALUControlE
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Operand forwarding selects (2'b11 falls back to the register file)
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Iterative multiplier FSM
  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one partial-product step per clock, low DATA_W bits kept.
// Latency: 1 start cycle + DATA_W RUN cycles busy, then one DONE cycle with the product valid.
// Backpressure: none; o_busy asks the pipeline to hold, operands are latched at start.
// Ports: i_clk/i_rst (sync, active-high), i_start (op is MUL), i_a/i_b operands,
//        o_busy (combinational), o_done (DONE state), o_product (accumulator).
module mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_product
);
  import mips_pkg::*;

  localparam int              CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  mul_state_e        r_state;
  mul_state_e        w_state_nxt;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= MUL_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MUL_IDLE: if (i_start) w_state_nxt = MUL_RUN;
      MUL_RUN:  if (r_cnt == LAST) w_state_nxt = MUL_DONE;
      MUL_DONE: w_state_nxt = MUL_IDLE;
      default:  w_state_nxt = MUL_IDLE;
    endcase
  end

  // Multiplicand shifts left, multiplier shifts right; bits above DATA_W are dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        MUL_IDLE: begin
          if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        MUL_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Busy already in the start cycle so the front end holds the MUL in E.
  assign o_busy    = !i_rst && ((r_state == MUL_RUN) || ((r_state == MUL_IDLE) && i_start));
  assign o_done    = (r_state == MUL_DONE);
  assign o_product = r_acc;

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: operand forwarding, ALU, dest-reg select, EX/MEM pipeline register.
// Latency: 1 cycle for ALU ops; MUL (EXEC_MULT_EN) takes 34 cycles, result in M after the 34th edge.
// Backpressure: BusyE (combinational) stalls F/D/E while a MUL runs; M receives bubbles meanwhile.
// Build option: define EXEC_MULT_EN to include the iterative multiplier (op 011 = MUL);
//   otherwise op 011 yields 0 and BusyE is tied low.
// Ports: CLK, RST (sync, active-high); E-side controls/operands/forward selects/ResultW in;
//   WriteRegE, BusyE combinational out; *M outputs are the EX/MEM register.
module execute_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RegWriteE,
  input  logic                  MemtoRegE,
  input  logic                  MemWriteE,
  input  logic [2:0]            ALUControlE,
  input  logic                  ALUSrcE,
  input  logic                  RegDstE,
  input  logic [DATA_W-1:0]     RD1_E,
  input  logic [DATA_W-1:0]     RD2_E,
  input  logic [DATA_W-1:0]     SignImmE,
  input  logic [REG_ADDR_W-1:0] RtE,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [DATA_W-1:0]     ResultW,
  output logic [REG_ADDR_W-1:0] WriteRegE,
  output logic                  BusyE,
  output logic                  RegWriteM,
  output logic                  MemtoRegM,
  output logic                  MemWriteM,
  output logic [DATA_W-1:0]     ALUOutM,
  output logic [DATA_W-1:0]     WriteDataM,
  output logic [REG_ADDR_W-1:0] WriteRegM
);
  import mips_pkg::*;

  logic [DATA_W-1:0] w_src_a;
  logic [DATA_W-1:0] w_write_data;
  logic [DATA_W-1:0] w_src_b;
  logic [DATA_W-1:0] w_alu_out;
  logic              w_busy;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_product;

  function automatic logic [DATA_W-1:0] fwd_sel(input logic [1:0]        sel,
                                                input logic [DATA_W-1:0] rf,
                                                input logic [DATA_W-1:0] wb,
                                                input logic [DATA_W-1:0] mem);
    case (sel)
      FWD_WB:  return wb;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

  // The MEM-stage forward source is this stage's own registered ALUOutM.
  assign w_src_a      = fwd_sel(ForwardAE, RD1_E, ResultW, ALUOutM);
  assign w_write_data = fwd_sel(ForwardBE, RD2_E, ResultW, ALUOutM);
  assign w_src_b      = ALUSrcE ? SignImmE : w_write_data;
  assign WriteRegE    = RegDstE ? RdE : RtE;

  always_comb begin
    w_alu_out = '0;
    case (ALUControlE)
      ALU_ADD: w_alu_out = w_src_a + w_src_b;
      ALU_SUB: w_alu_out = w_src_a - w_src_b;
      ALU_AND: w_alu_out = w_src_a & w_src_b;
      ALU_OR:  w_alu_out = w_src_a | w_src_b;
      ALU_SLT: w_alu_out = {{(DATA_W-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
      default: w_alu_out = '0;
    endcase
  end

`ifdef EXEC_MULT_EN
  logic w_mul_start;
  assign w_mul_start = (ALUControlE == ALU_MUL);

  mul_iter #(.DATA_W(DATA_W)) u_mul_iter (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_start   (w_mul_start),
    .i_a       (w_src_a),
    .i_b       (w_src_b),
    .o_busy    (w_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );
`else
  assign w_busy        = 1'b0;
  assign w_mul_done    = 1'b0;
  assign w_mul_product = '0;
`endif

  assign BusyE = w_busy;

  // EX/MEM register: no enable; a bubble is loaded while the multiplier is busy.
  always_ff @(posedge CLK) begin
    if (RST || w_busy) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE;
      ALUOutM    <= w_mul_done ? w_mul_product : w_alu_out;
      WriteDataM <= w_write_data;
      WriteRegM  <= WriteRegE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]    ALUControlE;
  logic [DW-1:0] RD1_E, RD2_E, SignImmE, ResultW;
  logic [AW-1:0] RtE, RdE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [AW-1:0] WriteRegE;
  logic          BusyE;
  logic          RegWriteM, MemtoRegM, MemWriteM;
  logic [DW-1:0] ALUOutM, WriteDataM;
  logic [AW-1:0] WriteRegM;

  always #5 CLK = ~CLK;

  execute_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .SignImmE(SignImmE), .RtE(RtE), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .WriteRegE(WriteRegE), .BusyE(BusyE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM)
  );

  typedef struct {
    logic          rw;
    logic          mtr;
    logic          mw;
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [AW-1:0] wr;
  } exp_t;

  exp_t          sb[$];
  int            n_err = 0;
  int            n_chk = 0;
  logic [DW-1:0] m_alu;  // model of the current ALUOutM, used as the MEM forward source

  function automatic logic [DW-1:0] alu_model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef EXEC_MULT_EN
      3'b011:  return a * b;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] fwd_model(input logic [1:0] s, input logic [DW-1:0] rf, input logic [DW-1:0] wb, input logic [DW-1:0] mem);
    if (s == 2'b01) return wb;
    if (s == 2'b10) return mem;
    return rf;
  endfunction

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  // Apply one E-stage instruction and push the M contents it should produce.
  task automatic drive(input logic [2:0] op, input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                       input logic [DW-1:0] imm, input logic [DW-1:0] resw,
                       input logic [1:0] fa, input logic [1:0] fb, input logic src, input logic dst,
                       input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                       input logic rw, input logic mtr, input logic mw);
    exp_t          e;
    logic [DW-1:0] a, wd, b;
    ALUControlE = op; RD1_E = rd1; RD2_E = rd2; SignImmE = imm; ResultW = resw;
    ForwardAE = fa; ForwardBE = fb; ALUSrcE = src; RegDstE = dst; RtE = rt; RdE = rd;
    RegWriteE = rw; MemtoRegE = mtr; MemWriteE = mw;
    a  = fwd_model(fa, rd1, resw, m_alu);
    wd = fwd_model(fb, rd2, resw, m_alu);
    b  = src ? imm : wd;
    e.rw = rw; e.mtr = mtr; e.mw = mw;
    e.alu = alu_model(op, a, b);
    e.wd  = wd;
    e.wr  = dst ? rd : rt;
    sb.push_back(e);
    m_alu = e.alu;
  endtask

  task automatic test_reset;
    exp_t e;
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ALUControlE = 3'($urandom_range(0, 7)); RD1_E = $urandom; RD2_E = $urandom; SignImmE = $urandom;
      ResultW = $urandom; ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
      ALUSrcE = 1'($urandom_range(0, 1)); RegDstE = 1'($urandom_range(0, 1));
      RtE = 5'($urandom_range(0, 31)); RdE = 5'($urandom_range(0, 31));
      RegWriteE = 1'b1; MemtoRegE = 1'b1; MemWriteE = 1'b1;
      cyc;
      n_chk++;
      if ({RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM, BusyE} !== '0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got rw=%b mtr=%b mw=%b alu=%h wd=%h wr=%0d busy=%b, want all 0",
                 i, RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM, BusyE);
      end
    end
    m_alu = '0;
    drive(3'b010, 32'd11, 32'd22, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0);
    RST = 1'b0;
    cyc;
    e = sb.pop_front();
    n_chk++;
    if ({RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM} !== {e.rw, e.mtr, e.mw, e.alu, e.wd, e.wr}) begin
      n_err++;
      $display("FAIL reset_release: got alu=%h wd=%h wr=%0d ctl=%b%b%b, want alu=%h wd=%h wr=%0d ctl=%b%b%b",
               ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM, e.alu, e.wd, e.wr, e.rw, e.mtr, e.mw);
    end
  endtask

  task automatic test_add_fwd;
    exp_t e;
    drive(3'b010, 32'd7, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    cyc;
    e = sb.pop_front();
    n_chk++;
    if (ALUOutM !== e.alu) begin
      n_err++; $display("FAIL add_setup: got %h want %h", ALUOutM, e.alu);
    end
    drive(3'b010, 32'd5, 32'd3, 32'd0, 32'd99, 2'b10, 2'b00, 1'b0, 1'b1, 5'd1, 5'd12, 1'b1, 1'b0, 1'b0);
    cyc;
    e = sb.pop_front();
    n_chk++;
    if (ALUOutM !== 32'd10 || WriteDataM !== 32'd3 || WriteRegM !== 5'd12) begin
      n_err++;
      $display("FAIL add_fwd_mem: got alu=%0d wd=%0d wr=%0d, want alu=10 wd=3 wr=12", ALUOutM, WriteDataM, WriteRegM);
    end
  endtask

  task automatic test_slt_imm;
    exp_t e;
    drive(3'b111, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 2'b00, 2'b00, 1'b1, 1'b0, 5'd9, 5'd17, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (WriteRegE !== 5'd9) begin
      n_err++; $display("FAIL write_reg_e_rt: got %0d want 9", WriteRegE);
    end
    cyc;
    e = sb.pop_front();
    n_chk++;
    if (ALUOutM !== 32'd1 || WriteRegM !== 5'd9) begin
      n_err++; $display("FAIL slt_imm: got alu=%h wr=%0d, want alu=1 wr=9", ALUOutM, WriteRegM);
    end
    // Unsigned compare would say 1 < 0xFFFFFFFF; signed must give 0 here.
    drive(3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd9, 5'd17, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (WriteRegE !== 5'd17) begin
      n_err++; $display("FAIL write_reg_e_rd: got %0d want 17", WriteRegE);
    end
    cyc;
    e = sb.pop_front();
    n_chk++;
    if (ALUOutM !== 32'd0 || WriteRegM !== 5'd17) begin
      n_err++; $display("FAIL slt_signed: got alu=%h wr=%0d, want alu=0 wr=17", ALUOutM, WriteRegM);
    end
  endtask

  task automatic test_back_to_back;
    exp_t       e;
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
`ifdef EXEC_MULT_EN
      if (op == 3'b011) op = 3'b110;
`endif
      drive(op, $urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      n_chk++;
      if (BusyE !== 1'b0) begin
        n_err++; $display("FAIL b2b_busy[%0d] op=%b: got %b want 0", i, op, BusyE);
      end
      cyc;
      e = sb.pop_front();
      n_chk++;
      if ({RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM} !== {e.rw, e.mtr, e.mw, e.alu, e.wd, e.wr}) begin
        n_err++;
        $display("FAIL b2b[%0d] op=%b: got alu=%h wd=%h wr=%0d ctl=%b%b%b, want alu=%h wd=%h wr=%0d ctl=%b%b%b", i, op,
                 ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM, e.alu, e.wd, e.wr, e.rw, e.mtr, e.mw);
      end
    end
  endtask

`ifdef EXEC_MULT_EN
  // Starts a MUL (FSM must be idle), holds it while busy and checks bubbles, busy length and result.
  task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AW-1:0] rd);
    exp_t e;
    int   nb;
    bit   done;
    drive(3'b011, a, b, $urandom, $urandom, 2'b00, 2'b00, 1'b0, 1'b1, 5'd2, rd, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (BusyE !== 1'b1) begin
      n_err++; $display("FAIL mul_start_busy: got %b want 1", BusyE);
    end
    nb = 1;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      cyc;
      n_chk++;
      if ({RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM} !== '0) begin
        n_err++;
        $display("FAIL mul_bubble[%0d]: got alu=%h wd=%h wr=%0d ctl=%b%b%b, want all 0",
                 k, ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM);
      end
      if (BusyE === 1'b1) begin
        nb++;
        // Operands were latched at start; redirecting A mid-run must not matter.
        if (k == 4) begin
          ForwardAE = 2'b01;
          ResultW   = $urandom;
        end
      end else begin
        done = 1;
      end
    end
    n_chk++;
    if (nb != 33) begin
      n_err++; $display("FAIL mul_busy_len: got %0d cycles want 33", nb);
    end
    ForwardAE = 2'b00;
    cyc;
    e = sb.pop_front();
    n_chk++;
    if ({RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM} !== {e.rw, e.mtr, e.mw, e.alu, e.wd, e.wr}) begin
      n_err++;
      $display("FAIL mul_result: got alu=%h wd=%h wr=%0d ctl=%b%b%b, want alu=%h wd=%h wr=%0d ctl=%b%b%b",
               ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM, e.alu, e.wd, e.wr, e.rw, e.mtr, e.mw);
    end
  endtask

  task automatic test_mul;
    run_mul(32'h0001_0003, 32'h0000_0005, 5'd20);
    n_chk++;
    if (ALUOutM !== 32'h0005_000F) begin
      n_err++; $display("FAIL mul_example: got %h want 0005000f", ALUOutM);
    end
    // Op 011 still held: the FSM is back in IDLE and starts a fresh run at once.
    run_mul(32'hDEAD_BEEF, 32'h1234_5679, 5'd21);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22);
  endtask

  task automatic test_mul_reset;
    exp_t e;
    drive(3'b011, 32'd1234, 32'd5678, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd2, 5'd23, 1'b1, 1'b0, 1'b0);
    repeat (10) cyc;
    n_chk++;
    if (BusyE !== 1'b1) begin
      n_err++; $display("FAIL mul_run10_busy: got %b want 1", BusyE);
    end
    RST = 1'b1;
    cyc;
    n_chk++;
    if ({RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM, BusyE} !== '0) begin
      n_err++;
      $display("FAIL mul_abort: got alu=%h wd=%h wr=%0d ctl=%b%b%b busy=%b, want all 0",
               ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM, BusyE);
    end
    sb.delete();
    m_alu = '0;
    drive(3'b001, 32'h0F0F_0000, 32'h0000_00F0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1);
    RST = 1'b0;
    #1;
    n_chk++;
    if (BusyE !== 1'b0) begin
      n_err++; $display("FAIL mul_abort_idle: got busy=%b want 0", BusyE);
    end
    cyc;
    e = sb.pop_front();
    n_chk++;
    if (ALUOutM !== 32'h0F0F_00F0 || WriteRegM !== 5'd6 || MemWriteM !== 1'b1) begin
      n_err++; $display("FAIL after_abort_or: got alu=%h wr=%0d mw=%b, want alu=0f0f00f0 wr=6 mw=1", ALUOutM, WriteRegM, MemWriteM);
    end
    run_mul(32'd300, 32'd7, 5'd24);
    n_chk++;
    if (ALUOutM !== 32'd2100) begin
      n_err++; $display("FAIL mul_after_abort: got %0d want 2100", ALUOutM);
    end
    // Replace the held MUL with an add in the same cycle, so no new run starts.
    drive(3'b010, 32'd1, 32'd1, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0);
    cyc;
    e = sb.pop_front();
    n_chk++;
    if (ALUOutM !== e.alu || BusyE !== 1'b0) begin
      n_err++; $display("FAIL mul_exit: got alu=%h busy=%b, want alu=%h busy=0", ALUOutM, BusyE, e.alu);
    end
  endtask
`else
  task automatic test_no_mul;
    exp_t e;
    drive(3'b011, 32'd6, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd2, 5'd25, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (BusyE !== 1'b0) begin
      n_err++; $display("FAIL no_mul_busy: got %b want 0", BusyE);
    end
    cyc;
    e = sb.pop_front();
    n_chk++;
    if (ALUOutM !== 32'd0 || WriteRegM !== 5'd25 || BusyE !== 1'b0) begin
      n_err++; $display("FAIL no_mul_result: got alu=%h wr=%0d busy=%b, want alu=0 wr=25 busy=0", ALUOutM, WriteRegM, BusyE);
    end
  endtask
`endif

  initial begin
    m_alu = '0;
    test_reset;
    test_add_fwd;
    test_slt_imm;
    test_back_to_back;
`ifdef EXEC_MULT_EN
    test_mul;
    test_mul_reset;
`else
    test_no_mul;
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
